// File: rtl/cub_scache_pkg.sv
// Shared constants, request record and address helpers for the scratch-cache bank arbiter.
// The bank geometry (depth, width, bank count) is fixed here and used by every file.
package cub_scache_pkg;

    localparam int REQ_CFLOW_WR = 0;
    localparam int REQ_CFLOW_RD = 1;
    localparam int REQ_CORE     = 2;
    localparam int NREQ_DEFAULT = 3;

    localparam int SCACHE_RAM_WDEPTH = 128;
    localparam int SCACHE_RAM_DWID   = 32;
    localparam int BANK_NUM          = 2;

    localparam int DWID    = SCACHE_RAM_DWID;
    localparam int WAW     = $clog2(SCACHE_RAM_WDEPTH);
    localparam int BANK_AW = $clog2(BANK_NUM);
    localparam int BAW     = WAW - BANK_AW;

    typedef struct packed {
        logic            we;
        logic [3:0]      be;
        logic [DWID-1:0] wdata;
        logic [WAW-1:0]  addr;
    } scache_req_t;

    // Word-interleaved: the low address bits pick the bank.
    function automatic logic [BANK_AW-1:0] bank_of(input logic [WAW-1:0] addr);
        return addr[BANK_AW-1:0];
    endfunction

    function automatic logic [BAW-1:0] bank_addr_of(input logic [WAW-1:0] addr);
        return addr[WAW-1:BANK_AW];
    endfunction

endpackage

// File: rtl/cub_scache_bank_arb_if.sv
// Requester-side and SRAM-side signal bundle of the scratch-cache bank arbiter.
// A requester holds arb_req and its attributes until arb_gnt; the response arrives as a one-cycle arb_rvalid pulse.
interface cub_scache_bank_arb_if
    import cub_scache_pkg::*;
#(
    parameter int NREQ = NREQ_DEFAULT
);
    logic                               arb_freeze;
    logic [NREQ-1:0]                    arb_req;
    logic [NREQ-1:0]                    arb_we;
    logic [NREQ-1:0][3:0]               arb_be;
    logic [NREQ-1:0][DWID-1:0]          arb_wdata;
    logic [NREQ-1:0][WAW-1:0]           arb_addr;
    logic [NREQ-1:0]                    arb_gnt;
    logic [NREQ-1:0]                    arb_rvalid;
    logic [NREQ-1:0][DWID-1:0]          arb_rdata;

    logic [BANK_NUM-1:0]                ram_en;
    logic [BANK_NUM-1:0]                ram_we;
    logic [BANK_NUM-1:0][3:0]           ram_bm;
    logic [BANK_NUM-1:0][BAW-1:0]       ram_addr;
    logic [BANK_NUM-1:0][DWID-1:0]      ram_wr_data;
    logic [BANK_NUM-1:0][DWID-1:0]      ram_rd_data;

    modport slave (
        input  arb_freeze, arb_req, arb_we, arb_be, arb_wdata, arb_addr, ram_rd_data,
        output arb_gnt, arb_rvalid, arb_rdata, ram_en, ram_we, ram_bm, ram_addr, ram_wr_data
    );

    modport master (
        output arb_freeze, arb_req, arb_we, arb_be, arb_wdata, arb_addr, ram_rd_data,
        input  arb_gnt, arb_rvalid, arb_rdata, ram_en, ram_we, ram_bm, ram_addr, ram_wr_data
    );

endinterface

// File: rtl/cub_scache_rr_arb.sv
// Round-robin picker for one bank: first requester at or after the pointer wins,
// and the pointer moves just past the winner only when a grant is issued.
module cub_scache_rr_arb #(
    parameter int NREQ = 3,
    parameter int PW   = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en_i,
    input  logic [NREQ-1:0] req_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [PW-1:0]   gnt_id_o,
    output logic            gnt_vld_o
);

    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW:0]   sum;
    logic [PW-1:0] idx;

    always_comb begin
        gnt_o     = '0;
        gnt_id_o  = '0;
        gnt_vld_o = 1'b0;
        sum       = '0;
        idx       = '0;
        for (int k = 0; k < NREQ; k++) begin
            sum = {1'b0, ptr_q} + (PW+1)'(k);
            if (sum >= (PW+1)'(NREQ)) begin
                sum = sum - (PW+1)'(NREQ);
            end
            idx = sum[PW-1:0];
            if (en_i && !gnt_vld_o && req_i[idx]) begin
                gnt_vld_o  = 1'b1;
                gnt_id_o   = idx;
                gnt_o[idx] = 1'b1;
            end
        end
        ptr_d = ptr_q;
        if (gnt_vld_o) begin
            ptr_d = (gnt_id_o == PW'(NREQ-1)) ? '0 : gnt_id_o + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/cub_scache_bank_arb.sv
// Shares the word-interleaved scratch-cache SRAM banks among NREQ requesters,
// one round-robin grant per bank per cycle, and routes the 1-cycle response back to its issuer.
module cub_scache_bank_arb
    import cub_scache_pkg::*;
#(
    parameter int NREQ = NREQ_DEFAULT
) (
    input logic                  clk,
    input logic                  rst_n,
    cub_scache_bank_arb_if.slave bus
);

    localparam int PW = $clog2(NREQ);

    scache_req_t                         req_s [NREQ];
    logic [BANK_NUM-1:0][NREQ-1:0]       cand;
    logic [BANK_NUM-1:0][NREQ-1:0]       bank_gnt;
    logic [BANK_NUM-1:0][PW-1:0]         win_id;
    logic [BANK_NUM-1:0]                 win_vld;
    logic                                grant_en;
    scache_req_t                         sel;

    logic [BANK_NUM-1:0]                 rsp_vld_q, rsp_vld_d;
    logic [BANK_NUM-1:0][PW-1:0]         rsp_id_q, rsp_id_d;
    logic [BANK_NUM-1:0]                 rsp_we_q, rsp_we_d;

    logic [NREQ-1:0]                     gnt_c;
    logic [NREQ-1:0]                     rvalid_c;
    logic [NREQ-1:0][DWID-1:0]           rdata_c;

    // Holding grants off during reset keeps the SRAM strobes inactive asynchronously.
    assign grant_en = ~bus.arb_freeze & rst_n;

    always_comb begin
        cand = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_s[i] = '{we: bus.arb_we[i], be: bus.arb_be[i],
                         wdata: bus.arb_wdata[i], addr: bus.arb_addr[i]};
            for (int b = 0; b < BANK_NUM; b++) begin
                cand[b][i] = bus.arb_req[i] && (bank_of(bus.arb_addr[i]) == BANK_AW'(b));
            end
        end
    end

    for (genvar gb = 0; gb < BANK_NUM; gb++) begin : g_bank
        cub_scache_rr_arb #(.NREQ(NREQ)) u_rr (
            .clk       (clk),
            .rst_n     (rst_n),
            .en_i      (grant_en),
            .req_i     (cand[gb]),
            .gnt_o     (bank_gnt[gb]),
            .gnt_id_o  (win_id[gb]),
            .gnt_vld_o (win_vld[gb])
        );
    end

    always_comb begin
        gnt_c = '0;
        for (int b = 0; b < BANK_NUM; b++) begin
            gnt_c = gnt_c | bank_gnt[b];
        end
        bus.arb_gnt = gnt_c;
    end

    always_comb begin
        bus.ram_en      = '0;
        bus.ram_we      = '0;
        bus.ram_bm      = '0;
        bus.ram_addr    = '0;
        bus.ram_wr_data = '0;
        rsp_we_d        = '0;
        sel             = '0;
        for (int b = 0; b < BANK_NUM; b++) begin
            if (win_vld[b]) begin
                sel                = req_s[win_id[b]];
                bus.ram_en[b]      = 1'b1;
                bus.ram_we[b]      = sel.we;
                bus.ram_bm[b]      = sel.we ? sel.be : 4'h0;
                bus.ram_addr[b]    = bank_addr_of(sel.addr);
                bus.ram_wr_data[b] = sel.wdata;
                rsp_we_d[b]        = sel.we;
            end
        end
        rsp_vld_d = win_vld;
        rsp_id_d  = win_id;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_vld_q <= '0;
            rsp_id_q  <= '0;
            rsp_we_q  <= '0;
        end else begin
            rsp_vld_q <= rsp_vld_d;
            rsp_id_q  <= rsp_id_d;
            rsp_we_q  <= rsp_we_d;
        end
    end

    // Writes are acknowledged too, with zero data, so the LSU sees one response per access.
    always_comb begin
        rvalid_c = '0;
        rdata_c  = '0;
        for (int b = 0; b < BANK_NUM; b++) begin
            if (rsp_vld_q[b]) begin
                rvalid_c[rsp_id_q[b]] = 1'b1;
                rdata_c[rsp_id_q[b]]  = rsp_we_q[b] ? '0 : bus.ram_rd_data[b];
            end
        end
        bus.arb_rvalid = rvalid_c;
        bus.arb_rdata  = rdata_c;
    end

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_hold_chk
        a_req_hold: assert property (@(posedge clk) disable iff (!rst_n)
            (bus.arb_req[gi] && !bus.arb_gnt[gi]) |=> (bus.arb_req[gi] && $stable(req_s[gi])));
    end

endmodule
